// File: rtl/microsequencer_if.sv
// Signal bundle between the microsequencer, its host and the 8-register ALU
// datapath. The master side is the microsequencer.
//
// Handshake rules:
//   host   : start is a request that is taken only while busy = 0, together
//            with entry_addr. busy is high from the next cycle until the
//            DONE cycle ends. done pulses for exactly one cycle.
//   x_in   : x_valid/x_ready. A transfer happens on a cycle where both are
//            high. x_valid must not wait for x_ready. x_ready is high only
//            when x_valid is already high and the current word loads R_in.
//   z_out  : z_valid is a pure qualifier with no back-pressure. z_out holds
//            a new result on every cycle z_valid is high.
interface microsequencer_if #(
   parameter int AW = 5
);
   localparam int UW = 20 + AW;

   // host control and control-store write port
   logic          start;
   logic [AW-1:0] entry_addr;
   logic          busy;
   logic          done;
   logic          uc_we;
   logic [AW-1:0] uc_addr;
   logic [UW-1:0] uc_wdata;

   // datapath operand / result handshakes
   logic          x_valid;
   logic          x_ready;
   logic          z_valid;

   // datapath controls
   logic [2:0]    fld_A;
   logic [2:0]    fld_B;
   logic [2:0]    fld_C;
   logic          ldRF;
   logic          selR_in;
   logic          ldR_in;
   logic          ldR_out;
   logic [1:0]    alu_op;

   // datapath registered flags
   logic          zero;
   logic          neg;
   logic          cy;

   modport master (
      input  start, entry_addr, uc_we, uc_addr, uc_wdata,
      input  x_valid, zero, neg, cy,
      output busy, done, x_ready, z_valid,
      output fld_A, fld_B, fld_C, ldRF, selR_in, ldR_in, ldR_out, alu_op
   );

   modport slave (
      output start, entry_addr, uc_we, uc_addr, uc_wdata,
      output x_valid, zero, neg, cy,
      input  busy, done, x_ready, z_valid,
      input  fld_A, fld_B, fld_C, ldRF, selR_in, ldR_in, ldR_out, alu_op
   );
endinterface

// File: rtl/microsequencer.sv
// Microprogram controller for the 8-register, 8-bit ALU datapath.
// A writable control store is read combinationally at the micro-PC; the
// current word drives the datapath and selects the next micro-PC. The word
// loading R_in stalls until an operand is offered on x_in.
//
// Microinstruction layout (UW = 20 + AW bits):
//   [2:0] fld_A  [5:3] fld_B  [8:6] fld_C
//   [9] ldRF  [10] selR_in  [11] ldR_in  [12] ldR_out  [14:13] alu_op
//   [16:15] seq  : NEXT / JUMP / BRANCH / HALT
//   [18:17] cond : zero / neg / cy / constant 1
//   [19] pol     : inverts the branch condition
//   [19+AW:20]   : branch / jump target
module microsequencer #(
   parameter int AW = 5
) (
   input  logic             clk,
   input  logic             rst,
   microsequencer_if.master bus,
   output logic [1:0]       dbg_state,
   output logic [AW-1:0]    dbg_upc
);
   localparam int UW    = 20 + AW;
   localparam int DEPTH = 1 << AW;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SEQ_NEXT   = 2'd0,
      SEQ_JUMP   = 2'd1,
      SEQ_BRANCH = 2'd2,
      SEQ_HALT   = 2'd3
   } seq_t;

   typedef enum logic [1:0] {
      COND_ZERO = 2'd0,
      COND_NEG  = 2'd1,
      COND_CY   = 2'd2,
      COND_ONE  = 2'd3
   } cond_t;

   state_t        state;
   state_t        state_nxt;
   logic [AW-1:0] upc;
   logic [AW-1:0] upc_nxt;
   logic [AW-1:0] upc_inc;

   // Control store: deliberately not reset so microcode survives rst.
   logic [UW-1:0] store [DEPTH];
   logic [UW-1:0] uword;

   // Fields of the current microinstruction.
   logic [2:0]    w_fld_a;
   logic [2:0]    w_fld_b;
   logic [2:0]    w_fld_c;
   logic          w_ldrf;
   logic          w_selr_in;
   logic          w_ldr_in;
   logic          w_ldr_out;
   logic [1:0]    w_alu_op;
   seq_t          w_seq;
   cond_t         w_cond;
   logic          w_pol;
   logic [AW-1:0] w_target;

   logic          stall;
   logic          flag;
   logic          take_branch;

   // Values presented on the bus.
   logic [2:0]    fld_a;
   logic [2:0]    fld_b;
   logic [2:0]    fld_c;
   logic          ldrf;
   logic          selr_in;
   logic          ldr_in;
   logic          ldr_out;
   logic [1:0]    alu_op;
   logic          x_ready;
   logic          done_pulse;
   logic          z_valid_q;

   assign uword     = store[upc];
   assign w_fld_a   = uword[2:0];
   assign w_fld_b   = uword[5:3];
   assign w_fld_c   = uword[8:6];
   assign w_ldrf    = uword[9];
   assign w_selr_in = uword[10];
   assign w_ldr_in  = uword[11];
   assign w_ldr_out = uword[12];
   assign w_alu_op  = uword[14:13];
   assign w_seq     = seq_t'(uword[16:15]);
   assign w_cond    = cond_t'(uword[18:17]);
   assign w_pol     = uword[19];
   assign w_target  = uword[19+AW:20];

   assign upc_inc   = upc + AW'(1);

   // A word that loads R_in cannot execute until an operand is offered.
   assign stall     = w_ldr_in & ~bus.x_valid;

   // Branch condition select; flags are the datapath's registered copies.
   always_comb begin
      flag = 1'b0;
      unique case (w_cond)
         COND_ZERO: flag = bus.zero;
         COND_NEG:  flag = bus.neg;
         COND_CY:   flag = bus.cy;
         COND_ONE:  flag = 1'b1;
         default:   flag = 1'b0;
      endcase
   end

   assign take_branch = flag ^ w_pol;

   // Control-store write port, open only while the sequencer is idle.
   always_ff @(posedge clk) begin
      if (state == S_IDLE && bus.uc_we) begin
         store[bus.uc_addr] <= bus.uc_wdata;
      end
   end

   // Next-state, next micro-PC and datapath control decode.
   always_comb begin
      state_nxt  = state;
      upc_nxt    = upc;
      fld_a      = 3'd0;
      fld_b      = 3'd0;
      fld_c      = 3'd0;
      ldrf       = 1'b0;
      selr_in    = 1'b0;
      ldr_in     = 1'b0;
      ldr_out    = 1'b0;
      alu_op     = 2'd0;
      x_ready    = 1'b0;
      done_pulse = 1'b0;

      unique case (state)
         S_IDLE: begin
            if (bus.start) begin
               upc_nxt   = bus.entry_addr;
               state_nxt = S_RUN;
            end
         end

         S_RUN: begin
            // Selects and ALU op follow the word even while stalled, so the
            // datapath flags track the stalled instruction's own result.
            fld_a   = w_fld_a;
            fld_b   = w_fld_b;
            fld_c   = w_fld_c;
            selr_in = w_selr_in;
            alu_op  = w_alu_op;
            if (!stall) begin
               ldrf    = w_ldrf;
               ldr_in  = w_ldr_in;
               ldr_out = w_ldr_out;
               // Not stalled, so a word loading R_in implies x_valid is high.
               x_ready = w_ldr_in;
               unique case (w_seq)
                  SEQ_NEXT:   upc_nxt = upc_inc;
                  SEQ_JUMP:   upc_nxt = w_target;
                  SEQ_BRANCH: upc_nxt = take_branch ? w_target : upc_inc;
                  SEQ_HALT:   state_nxt = S_DONE;
                  default:    upc_nxt = upc_inc;
               endcase
            end
         end

         S_DONE: begin
            done_pulse = 1'b1;
            state_nxt  = S_IDLE;
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State and micro-PC registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         upc   <= '0;
      end else begin
         state <= state_nxt;
         upc   <= upc_nxt;
      end
   end

   // z_valid lines up with the datapath's registered z_out.
   always_ff @(posedge clk) begin
      if (rst) begin
         z_valid_q <= 1'b0;
      end else begin
         z_valid_q <= ldr_out;
      end
   end

   assign bus.fld_A   = fld_a;
   assign bus.fld_B   = fld_b;
   assign bus.fld_C   = fld_c;
   assign bus.ldRF    = ldrf;
   assign bus.selR_in = selr_in;
   assign bus.ldR_in  = ldr_in;
   assign bus.ldR_out = ldr_out;
   assign bus.alu_op  = alu_op;
   assign bus.x_ready = x_ready;
   assign bus.done    = done_pulse;
   assign bus.busy    = (state != S_IDLE);
   assign bus.z_valid = z_valid_q;

   assign dbg_state   = state;
   assign dbg_upc     = upc;
endmodule

// File: tb/tb_microsequencer.sv
// Directed bench for microsequencer. Contains a small behavioural model of
// the 8-register ALU datapath (00 pass A, 01 A+B, 10 A-B, 11 A+1; flags
// registered every cycle), microcode loaders and per-program expectations.
module tb_microsequencer;
   localparam int AW = 5;
   localparam int UW = 20 + AW;

   localparam logic [1:0] NXT = 2'd0;
   localparam logic [1:0] JMP = 2'd1;
   localparam logic [1:0] BRN = 2'd2;
   localparam logic [1:0] HLT = 2'd3;

   logic          clk;
   logic          rst;
   logic [1:0]    dbg_state;
   logic [AW-1:0] dbg_upc;
   logic [7:0]    x_in;
   logic [7:0]    z_out;

   microsequencer_if #(.AW(AW)) bus ();

   microsequencer #(.AW(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state),
      .dbg_upc   (dbg_upc)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   // ---------------- datapath model ----------------
   logic [7:0] rf [8];
   logic [7:0] r_out;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [7:0] alu_y;
   logic       alu_c;

   initial begin
      for (int i = 0; i < 8; i++) rf[i] = 8'h00;
      r_out    = 8'h00;
      bus.zero = 1'b0;
      bus.neg  = 1'b0;
      bus.cy   = 1'b0;
   end

   always_comb begin
      alu_a = rf[bus.fld_A];
      alu_b = rf[bus.fld_B];
      case (bus.alu_op)
         2'b00:   {alu_c, alu_y} = {1'b0, alu_a};
         2'b01:   {alu_c, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
         2'b10:   {alu_c, alu_y} = {1'b0, alu_a} - {1'b0, alu_b};
         default: {alu_c, alu_y} = {1'b0, alu_a} + 9'd1;
      endcase
   end

   always @(posedge clk) begin
      bus.zero <= (alu_y == 8'h00);
      bus.neg  <= alu_y[7];
      bus.cy   <= alu_c;
      if (bus.ldRF) rf[bus.fld_C] <= bus.selR_in ? x_in : alu_y;
      if (bus.ldR_out) r_out <= alu_y;
   end

   assign z_out = r_out;

   // ---------------- scoreboard ----------------
   int         n_vec = 0;
   int         n_bad = 0;
   logic [7:0] exp_q [$];
   logic [7:0] x_q [$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Every z_valid must match the next expected result.
   always @(negedge clk) begin
      if (bus.z_valid) begin
         if (exp_q.size() == 0) check_val("z_spurious", 32'd1, 32'd0);
         else                   check_val("z_out", 32'(z_out), 32'(exp_q.pop_front()));
      end
   end

   // ---------------- driver tasks ----------------
   int              xv_delay;
   int              we_at;
   logic [AW-1:0]   we_addr;
   logic [UW-1:0]   we_data;
   int              st_at;
   logic [AW-1:0]   st_addr;
   int              r_busy;
   int              r_done_at;
   int              r_zv_at;
   int              r_xr_first;
   int              r_stall_bad;
   int              r_sub;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [UW-1:0] mk(
      input logic [2:0] fa, input logic [2:0] fb, input logic [2:0] fc,
      input logic ldrf, input logic selr, input logic ldrin, input logic ldrout,
      input logic [1:0] alu, input logic [1:0] seq, input logic [1:0] cond,
      input logic pol, input logic [AW-1:0] tgt);
      return {tgt, pol, cond, seq, alu, ldrout, ldrin, selr, ldrf, fc, fb, fa};
   endfunction

   task automatic write_uc(input logic [AW-1:0] addr, input logic [UW-1:0] data);
      bus.uc_we    = 1'b1;
      bus.uc_addr  = addr;
      bus.uc_wdata = data;
      tick();
      bus.uc_we    = 1'b0;
   endtask

   task automatic clear_knobs();
      xv_delay = 0;
      we_at    = -99;
      we_addr  = '0;
      we_data  = '0;
      st_at    = -99;
      st_addr  = '0;
   endtask

   // Starts at entry and follows the run for at most limit cycles,
   // recording busy length and event cycles (index 0 = first RUN cycle).
   task automatic run_prog(input logic [AW-1:0] entry, input int limit);
      r_busy = 0; r_done_at = -1; r_zv_at = -1; r_xr_first = -1;
      r_stall_bad = 0; r_sub = 0;
      bus.start      = 1'b1;
      bus.entry_addr = entry;
      bus.uc_we      = (we_at == -1);
      bus.uc_addr    = we_addr;
      bus.uc_wdata   = we_data;
      bus.x_valid    = 1'b0;
      tick();
      bus.start = 1'b0;
      bus.uc_we = 1'b0;
      for (int c = 0; c < limit; c++) begin
         bus.x_valid    = (c >= xv_delay);
         x_in           = (x_q.size() > 0) ? x_q[0] : 8'h00;
         bus.uc_we      = (c == we_at);
         bus.start      = (c == st_at);
         bus.entry_addr = st_addr;
         #1;
         if (!bus.busy) break;
         r_busy++;
         if (bus.done && r_done_at < 0) r_done_at = c;
         if (bus.z_valid && r_zv_at < 0) r_zv_at = c;
         if (bus.x_ready && r_xr_first < 0) r_xr_first = c;
         if (c < xv_delay && (dbg_upc != entry || bus.ldRF || bus.ldR_in ||
                              bus.ldR_out || bus.x_ready)) r_stall_bad++;
         if (bus.ldRF && bus.alu_op == 2'b10 && !bus.selR_in) r_sub++;
         if (bus.x_ready && x_q.size() > 0) void'(x_q.pop_front());
         tick();
      end
      bus.x_valid = 1'b0;
      bus.start   = 1'b0;
      bus.uc_we   = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   logic [UW-1:0] p1_w2;

   initial begin
      rst = 1'b1;
      bus.start = 1'b0; bus.entry_addr = '0; bus.uc_we = 1'b0;
      bus.uc_addr = '0; bus.uc_wdata = '0; bus.x_valid = 1'b0;
      x_in = 8'h00;
      clear_knobs();
      tick(); tick();
      rst = 1'b0;
      #1;
      check_val("rst_state", 32'(dbg_state), 32'd0);
      check_val("rst_upc", 32'(dbg_upc), 32'd0);
      check_val("rst_busy", 32'(bus.busy), 32'd0);
      check_val("rst_done", 32'(bus.done), 32'd0);
      check_val("rst_x_ready", 32'(bus.x_ready), 32'd0);
      check_val("rst_z_valid", 32'(bus.z_valid), 32'd0);
      check_val("rst_enables", 32'({bus.ldRF, bus.ldR_in, bus.ldR_out}), 32'd0);
      check_val("rst_fields", 32'({bus.fld_A, bus.fld_B, bus.fld_C, bus.alu_op, bus.selR_in}), 32'd0);
      tick();

      // Program 1: R1 = x_in; R1 = R1 + 1; R_out = R1, HALT.
      p1_w2 = mk(3'd1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, HLT, 2'd0, 1'b0, 5'd0);
      write_uc(5'd0, mk(3'd0, 3'd0, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, NXT, 2'd0, 1'b0, 5'd0));
      write_uc(5'd1, mk(3'd1, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, NXT, 2'd0, 1'b0, 5'd0));
      write_uc(5'd2, p1_w2);
      // Countdown: R2 = x, R3 = x, loop R2 -= R3 until zero, output R2.
      write_uc(5'd4, mk(3'd0, 3'd0, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, NXT, 2'd0, 1'b0, 5'd0));
      write_uc(5'd5, mk(3'd0, 3'd0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, NXT, 2'd0, 1'b0, 5'd0));
      write_uc(5'd6, mk(3'd2, 3'd3, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, NXT, 2'd0, 1'b0, 5'd0));
      write_uc(5'd7, mk(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, BRN, 2'd0, 1'b1, 5'd6));
      write_uc(5'd8, mk(3'd2, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, HLT, 2'd0, 1'b0, 5'd0));
      // Carry branch: R4 = x, R5 = x, R4 + R5, branch on cy to 15.
      write_uc(5'd10, mk(3'd0, 3'd0, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, NXT, 2'd0, 1'b0, 5'd0));
      write_uc(5'd11, mk(3'd0, 3'd0, 3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, NXT, 2'd0, 1'b0, 5'd0));
      write_uc(5'd12, mk(3'd4, 3'd5, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, NXT, 2'd0, 1'b0, 5'd0));
      write_uc(5'd13, mk(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, BRN, 2'd2, 1'b0, 5'd15));
      write_uc(5'd14, mk(3'd4, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, HLT, 2'd0, 1'b0, 5'd0));
      write_uc(5'd15, mk(3'd5, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, HLT, 2'd0, 1'b0, 5'd0));
      // Constant condition: branch to 25 (R1+1) or fall to 21 (R1).
      write_uc(5'd20, mk(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, BRN, 2'd3, 1'b1, 5'd25));
      write_uc(5'd21, mk(3'd1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, HLT, 2'd0, 1'b0, 5'd0));
      write_uc(5'd25, mk(3'd1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, HLT, 2'd0, 1'b0, 5'd0));
      // Self loop and a plain NEXT at the top address.
      write_uc(5'd28, mk(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, JMP, 2'd0, 1'b0, 5'd28));
      write_uc(5'd31, '0);

      // Basic run: 0x41 + 1.
      clear_knobs(); x_q.push_back(8'h41); exp_q.push_back(8'h42);
      run_prog(5'd0, 60);
      check_val("p1_busy_cycles", 32'(r_busy), 32'd4);
      check_val("p1_done_at", 32'(r_done_at), 32'd3);
      check_val("p1_zv_at", 32'(r_zv_at), 32'd3);
      check_val("p1_xr_first", 32'(r_xr_first), 32'd0);
      check_val("p1_done_after", 32'(bus.done), 32'd0);

      // Operand arrives 5 cycles late.
      clear_knobs(); xv_delay = 5; x_q.push_back(8'h41); exp_q.push_back(8'h42);
      run_prog(5'd0, 60);
      check_val("stall_busy_cycles", 32'(r_busy), 32'd9);
      check_val("stall_done_at", 32'(r_done_at), 32'd8);
      check_val("stall_zv_at", 32'(r_zv_at), 32'd8);
      check_val("stall_xr_first", 32'(r_xr_first), 32'd5);
      check_val("stall_hold", 32'(r_stall_bad), 32'd0);

      // Countdown from 3 by 1.
      clear_knobs(); x_q.push_back(8'h03); x_q.push_back(8'h01); exp_q.push_back(8'h00);
      run_prog(5'd4, 60);
      check_val("cnt_subtracts", 32'(r_sub), 32'd3);
      check_val("cnt_busy_cycles", 32'(r_busy), 32'd10);

      // 0xFF + 0x01 sets cy: branch taken, R5 + 1.
      clear_knobs(); x_q.push_back(8'hFF); x_q.push_back(8'h01); exp_q.push_back(8'h02);
      run_prog(5'd10, 60);
      check_val("cy1_busy_cycles", 32'(r_busy), 32'd6);
      // 0x01 + 0x01 clears cy: fall through, R4.
      clear_knobs(); x_q.push_back(8'h01); x_q.push_back(8'h01); exp_q.push_back(8'h01);
      run_prog(5'd10, 60);
      check_val("cy0_busy_cycles", 32'(r_busy), 32'd6);

      // Inverted constant never branches; R1 still 0x42.
      clear_knobs(); exp_q.push_back(8'h42);
      run_prog(5'd20, 60);
      check_val("never_busy_cycles", 32'(r_busy), 32'd3);
      write_uc(5'd20, mk(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, BRN, 2'd3, 1'b0, 5'd25));
      clear_knobs(); exp_q.push_back(8'h43);
      run_prog(5'd20, 60);
      check_val("always_busy_cycles", 32'(r_busy), 32'd3);

      // NEXT from 31 wraps to 0.
      clear_knobs(); x_q.push_back(8'h41); exp_q.push_back(8'h42);
      run_prog(5'd31, 60);
      check_val("wrap_busy_cycles", 32'(r_busy), 32'd5);
      check_val("wrap_xr_first", 32'(r_xr_first), 32'd1);

      // Store write and start while running are both ignored.
      clear_knobs(); we_at = 1; we_addr = 5'd2;
      we_data = mk(3'd1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, HLT, 2'd0, 1'b0, 5'd0);
      st_at = 1; st_addr = 5'd20;
      x_q.push_back(8'h41); exp_q.push_back(8'h42);
      run_prog(5'd0, 60);
      check_val("busy_ignore_cycles", 32'(r_busy), 32'd4);
      check_val("busy_ignore_idle", 32'(bus.busy), 32'd0);
      clear_knobs(); x_q.push_back(8'h41); exp_q.push_back(8'h42);
      run_prog(5'd0, 60);
      check_val("readback_cycles", 32'(r_busy), 32'd4);

      // Write and start together in IDLE: both take effect.
      clear_knobs(); we_at = -1; we_addr = 5'd2;
      we_data = mk(3'd1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, HLT, 2'd0, 1'b0, 5'd0);
      x_q.push_back(8'h41); exp_q.push_back(8'h43);
      run_prog(5'd0, 60);
      check_val("we_start_cycles", 32'(r_busy), 32'd4);
      clear_knobs();
      write_uc(5'd2, p1_w2);

      // Reset while stalled on x_in.
      bus.start = 1'b1; bus.entry_addr = 5'd0; bus.x_valid = 1'b0;
      tick();
      bus.start = 1'b0;
      tick(); tick();
      #1;
      check_val("pre_rst_stall_upc", 32'(dbg_upc), 32'd0);
      check_val("pre_rst_stall_busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check_val("rst_stall_state", 32'(dbg_state), 32'd0);
      check_val("rst_stall_busy", 32'(bus.busy), 32'd0);
      check_val("rst_stall_enables", 32'({bus.ldRF, bus.ldR_in, bus.ldR_out, bus.x_ready}), 32'd0);

      // Self loop keeps busy high until reset.
      clear_knobs();
      run_prog(5'd28, 40);
      #1;
      check_val("loop_busy_cycles", 32'(r_busy), 32'd40);
      check_val("loop_still_busy", 32'(bus.busy), 32'd1);
      check_val("loop_upc", 32'(dbg_upc), 32'd28);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check_val("rst_run_state", 32'(dbg_state), 32'd0);
      check_val("rst_run_busy", 32'(bus.busy), 32'd0);
      check_val("rst_run_upc", 32'(dbg_upc), 32'd0);
      check_val("rst_run_enables", 32'({bus.ldRF, bus.ldR_in, bus.ldR_out, bus.z_valid}), 32'd0);
      tick();
      check_val("rst_run_stays_idle", 32'(bus.busy), 32'd0);

      // Restart runs the stored program.
      clear_knobs(); x_q.push_back(8'h41); exp_q.push_back(8'h42);
      run_prog(5'd0, 60);
      check_val("restart_cycles", 32'(r_busy), 32'd4);

      tick(); tick();
      check_val("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
